rs_issue_scheduler: RTL and testbench
=====================================

// Module: rs_issue_scheduler
// PURPOSE
//  Dual-port issue scheduler between the reservation station and two functional-unit (FU) issue ports.
//  Each cycle it picks up to two ready RS entries, one per port, using a rotating scan pointer.
//  It tracks per-FU input credits and masks entries already granted but not yet cleared by the RS.
//  A starvation override forces issue of any entry left waiting too long.
// PARAMETERS
//  N             8   RS entries; power of 2, >=4
//  FU_CREDITS    2   input-queue slots per FU; credit counters are $clog2(FU_CREDITS+1) bits
//  STARVE_LIMIT  15  cycles an eligible entry may wait before it is forced; counters $clog2(STARVE_LIMIT+1) bits
// PORTS
//  clock          in   1          system clock
//  reset          in   1          synchronous, active-high
//  req            in   N          entry ready-to-issue vector from RS
//  en             in   1          issue enable; when 0, no grants and no state advance except credit returns
//  flush          in   1          squash: drop pending/starvation state
//  rotator        in   ROTATION_TYPE  pointer policy: NONE, WALKING, JUMPING, RANDOM
//  credit_return  in   2          FU p frees one input slot (pulse)
//  gnt0, gnt1     out  N          one-hot grant to port 0 / port 1; all-zero when no grant
//  gnt0_idx/gnt1_idx out $clog2(N)  binary index of the grant; 0 when invalid
//  gnt_valid      out  2          bit p = port p granted this cycle
// BEHAVIOUR
//  Grants are combinational from state plus inputs: zero latency, same-cycle grant.
//  State registers: ptr, jump_toggle, pend[N], starve_cnt[N], credit[2].
//  Reset: ptr=0, jump_toggle=0, pend=0, starve_cnt=0, credit[p]=FU_CREDITS. While reset=1, all grant outputs =0.
//  eligible = req & ~pend. No grants when en=0, flush=1, or reset=1.
//  Port p is available iff credit[p]!=0.
//  Port 0 scan: first eligible index ascending from ptr, wrapping N-1 -> 0.
//  Port 1 scan: first eligible index descending from ptr-1 (mod N), wrapping 0 -> N-1.
//  Same-entry conflict (only one eligible entry): port 0 takes it if available, else port 1; never both.
//  Starvation override: if any eligible entry has starve_cnt == STARVE_LIMIT, the lowest such index replaces port 0's pick.
//    If port 0 is unavailable, it replaces port 1's pick instead. The other port then scans excluding that entry.
//  starve_cnt[i]:
//    - clears when entry i is granted or eligible[i]=0;
//    - otherwise increments while en=1, saturating at STARVE_LIMIT.
//  pend[i]:
//    - set the cycle after entry i is granted;
//    - clears when req[i]=0;
//    - set and clear in the same cycle: set wins (newly granted).
//    - prevents double issue while the RS clear is in flight.
//  credit[p]:
//    - -1 on grant, +1 on credit_return[p], both together: unchanged;
//    - a return at FU_CREDITS is ignored and flagged by an assertion.
//  ptr advances only in cycles with en=1 and at least one grant:
//    - NONE: ptr=0
//    - WALKING: ptr+1
//    - JUMPING: ptr+N/2 when jump_toggle=0, else ptr+N/2+1; jump_toggle flips each advance
//    - RANDOM: behaves as WALKING
//    All pointer arithmetic is mod N, by natural width truncation.
//  flush: clears pend and starve_cnt next cycle; ptr and credits are kept (FUs still return credits). Grants are zero during the flush cycle.
//  reset mid-operation overrides everything; in-flight credit_returns during reset are discarded.
// STRUCTURE
//  ROTATION_TYPE comes from the shared project header package; no new typedefs are needed.
//  The wrapped-scan function (one-hot result from vector, start index, direction) is shared by both ports.
//  Sub-module: starve_tracker (per-entry counters, saturation, lowest-index-starved select).
//  Onehot->binary index uses the existing onehot_to_binary module.
// TESTING (N=8, FU_CREDITS=2, STARVE_LIMIT=15 unless noted)
//  1. reset, req=8'b1001_0010, ptr=0, WALKING -> gnt0=idx1, gnt1=idx7; next cycle pend=8'b1000_0010, ptr=1
//  2. req=8'b0000_0100 only, both credits -> gnt0=idx2, gnt_valid=2'b01; same with credit[0]=0 -> gnt1=idx2, gnt_valid=2'b10
//  3. three grants on port 0 without returns -> the third cycle gives no port-0 grant; one credit_return -> port 0 grants next cycle
//  4. hold req[5]=1, RS never clears it -> exactly one grant of idx5, then none until req[5] drops and rises again
//  5. STARVE_LIMIT=3, NONE rotation, req=8'hFF, RS clears/re-raises entries 0,7 each cycle -> entry 3 forced on port 0 after 3 waiting cycles
//  6. flush with pend=8'hFF -> zero grants that cycle; next cycle req=8'h01 grants idx0. JUMPING from ptr=0 -> ptr sequence 4,1,5,2

Source files
------------

// File: rtl/rs_issue_scheduler_pkg.sv
// Shared scheduler types: pointer rotation policy and port count.
package rs_issue_scheduler_pkg;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        WALKING = 2'd1,
        JUMPING = 2'd2,
        RANDOM  = 2'd3
    } rotation_type_t;

    localparam int unsigned NUM_PORTS = 2;

endpackage

// File: rtl/onehot_to_binary.sv
// One-hot to binary index encoder; all-zero input yields index 0.
module onehot_to_binary #(
    parameter int unsigned N = 8,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] onehot,
    output logic [W-1:0] binary
);

    always_comb begin
        binary = '0;
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) begin
                binary = binary | W'(i);
            end
        end
    end

endmodule

// File: rtl/rs_issue_scheduler_starve_tracker.sv
// Per-entry wait counters with saturation; selects the lowest-index starved entry.
module rs_issue_scheduler_starve_tracker #(
    parameter int unsigned N            = 8,
    parameter int unsigned STARVE_LIMIT = 15
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic         flush,
    input  logic [N-1:0] eligible,
    input  logic [N-1:0] granted,
    output logic         starve_any_c,
    output logic [N-1:0] starve_sel_c
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] cnt [N];
    logic [N-1:0]  starved;

    always_comb begin
        starved = '0;
        for (int i = 0; i < N; i++) begin
            starved[i] = eligible[i] && (cnt[i] == LIMIT);
        end
    end

    // Isolate the lowest set bit.
    assign starve_sel_c = starved & (~starved + N'(1));
    assign starve_any_c = |starved;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else if (en) begin
            for (int i = 0; i < N; i++) begin
                if (granted[i] || !eligible[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] != LIMIT) begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/rs_issue_scheduler.sv
// Dual-port RS issue scheduler: rotating-pointer scan, per-FU credits,
// in-flight pending mask and starvation override. Grants are same-cycle.
module rs_issue_scheduler
    import rs_issue_scheduler_pkg::*;
#(
    parameter int unsigned N            = 8,
    parameter int unsigned FU_CREDITS   = 2,
    parameter int unsigned STARVE_LIMIT = 15
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic                 en,
    input  logic                 flush,
    input  rotation_type_t       rotator,
    input  logic [1:0]           credit_return,
    output logic [N-1:0]         gnt0,
    output logic [N-1:0]         gnt1,
    output logic [$clog2(N)-1:0] gnt0_idx,
    output logic [$clog2(N)-1:0] gnt1_idx,
    output logic [1:0]           gnt_valid
);

    localparam int unsigned IW  = $clog2(N);
    localparam int unsigned CRW = $clog2(FU_CREDITS + 1);
    localparam logic [CRW-1:0] CREDIT_FULL = CRW'(FU_CREDITS);

    logic [IW-1:0]  ptr;
    logic           jump_toggle;
    logic [N-1:0]   pend;
    logic [CRW-1:0] credit [NUM_PORTS];

    logic [N-1:0] eligible;
    logic [N-1:0] pick0;
    logic [N-1:0] pick1;
    logic [N-1:0] granted;
    logic [1:0]   avail;
    logic [1:0]   ret_ok;
    logic         issue_ok;
    logic         starve_any_c;
    logic [N-1:0] starve_sel_c;

    // First set bit of vec walking from start, upward or downward, wrapping mod N.
    function automatic logic [N-1:0] wrap_scan(
        input logic [N-1:0]  vec,
        input logic [IW-1:0] start,
        input logic          descend
    );
        logic [N-1:0]  result;
        logic [IW-1:0] idx;
        logic          found;
        result = '0;
        found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = descend ? (start - IW'(k)) : (start + IW'(k));
            if (!found && vec[idx]) begin
                result[idx] = 1'b1;
                found       = 1'b1;
            end
        end
        return result;
    endfunction

    assign eligible = req & ~pend;
    assign issue_ok = en && !flush && !reset;

    always_comb begin
        avail  = '0;
        ret_ok = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            avail[p]  = credit[p] != '0;
            ret_ok[p] = credit_return[p] && (credit[p] != CREDIT_FULL);
        end
    end

    // Port selection; a starved entry preempts port 0, or port 1 when port 0 has no credit.
    always_comb begin
        pick0 = '0;
        pick1 = '0;
        if (issue_ok) begin
            if (starve_any_c && avail[0]) begin
                pick0 = starve_sel_c;
                if (avail[1]) begin
                    pick1 = wrap_scan(eligible & ~starve_sel_c, ptr - IW'(1), 1'b1);
                end
            end else if (starve_any_c && avail[1]) begin
                pick1 = starve_sel_c;
            end else begin
                if (avail[0]) begin
                    pick0 = wrap_scan(eligible, ptr, 1'b0);
                end
                if (avail[1]) begin
                    pick1 = wrap_scan(eligible & ~pick0, ptr - IW'(1), 1'b1);
                end
            end
        end
    end

    assign granted   = pick0 | pick1;
    assign gnt0      = pick0;
    assign gnt1      = pick1;
    assign gnt_valid = {|pick1, |pick0};

    onehot_to_binary #(.N(N), .W(IW)) u_idx0 (.onehot(pick0), .binary(gnt0_idx));
    onehot_to_binary #(.N(N), .W(IW)) u_idx1 (.onehot(pick1), .binary(gnt1_idx));

    rs_issue_scheduler_starve_tracker #(
        .N            (N),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clock        (clock),
        .reset        (reset),
        .en           (en),
        .flush        (flush),
        .eligible     (eligible),
        .granted      (granted),
        .starve_any_c (starve_any_c),
        .starve_sel_c (starve_sel_c)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr         <= '0;
            jump_toggle <= 1'b0;
            pend        <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                credit[p] <= CREDIT_FULL;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                credit[p] <= credit[p] - CRW'(gnt_valid[p]) + CRW'(ret_ok[p]);
            end
            // Pending holds until the RS drops the request; a fresh grant wins.
            if (flush) begin
                pend <= '0;
            end else if (en) begin
                pend <= granted | (pend & req);
            end
            if (gnt_valid != 2'b00) begin
                case (rotator)
                    NONE: ptr <= '0;
                    JUMPING: begin
                        ptr         <= ptr + IW'(N / 2) + IW'(jump_toggle);
                        jump_toggle <= ~jump_toggle;
                    end
                    default: ptr <= ptr + IW'(1);
                endcase
            end
        end
    end

    // A credit return with no outstanding slot indicates an FU protocol error.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_credit_chk
        assert property (@(posedge clock) disable iff (reset)
            !(credit_return[p] && (credit[p] == CREDIT_FULL)));
    end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Bench for rs_issue_scheduler: directed scenarios plus random traffic against a behavioural model.
module tb_rs_issue_scheduler;
    import rs_issue_scheduler_pkg::*;

    localparam int NE    = 8;
    localparam int CRED  = 2;
    localparam int LIMIT = 15;

    logic           clock;
    logic           reset;
    logic [NE-1:0]  req;
    logic           en;
    logic           flush;
    rotation_type_t rotator;
    logic [1:0]     credit_return;
    logic [NE-1:0]  gnt0;
    logic [NE-1:0]  gnt1;
    logic [2:0]     gnt0_idx;
    logic [2:0]     gnt1_idx;
    logic [1:0]     gnt_valid;

    rs_issue_scheduler #(.N(NE), .FU_CREDITS(CRED), .STARVE_LIMIT(LIMIT)) dut (
        .clock         (clock),
        .reset         (reset),
        .req           (req),
        .en            (en),
        .flush         (flush),
        .rotator       (rotator),
        .credit_return (credit_return),
        .gnt0          (gnt0),
        .gnt1          (gnt1),
        .gnt0_idx      (gnt0_idx),
        .gnt1_idx      (gnt1_idx),
        .gnt_valid     (gnt_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Behavioural model state
    int m_ptr, m_tog;
    bit m_pend [NE];
    int m_starve [NE];
    int m_credit [2];
    int e0, e1;

    // Last sampled DUT outputs
    logic [NE-1:0] s_gnt0, s_gnt1;
    logic [2:0]    s_idx0, s_idx1;
    logic [1:0]    s_valid;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int scan(input logic [NE-1:0] el, input int start, input bit up, input int skip);
        for (int k = 0; k < NE; k++) begin
            int i;
            i = up ? (start + k) % NE : (start - k + 2 * NE) % NE;
            if (el[i] && i != skip) return i;
        end
        return -1;
    endfunction

    task automatic predict(input logic rst, input logic [NE-1:0] rq, input logic e, input logic fl);
        logic [NE-1:0] el;
        int st;
        bit av0, av1;
        e0 = -1;
        e1 = -1;
        if (rst || !e || fl) return;
        for (int i = 0; i < NE; i++) el[i] = rq[i] && !m_pend[i];
        st = -1;
        for (int i = 0; i < NE; i++) if (el[i] && m_starve[i] == LIMIT && st < 0) st = i;
        av0 = m_credit[0] > 0;
        av1 = m_credit[1] > 0;
        if (st >= 0 && av0) begin
            e0 = st;
            if (av1) e1 = scan(el, m_ptr + NE - 1, 1'b0, st);
        end else if (st >= 0 && av1) begin
            e1 = st;
        end else begin
            if (av0) e0 = scan(el, m_ptr, 1'b1, -1);
            if (av1) e1 = scan(el, m_ptr + NE - 1, 1'b0, e0);
        end
    endtask

    task automatic update(input logic rst, input logic [NE-1:0] rq, input logic e, input logic fl,
                          input rotation_type_t rt, input logic [1:0] cr);
        if (rst) begin
            m_ptr = 0;
            m_tog = 0;
            for (int i = 0; i < NE; i++) begin
                m_pend[i] = 0;
                m_starve[i] = 0;
            end
            m_credit[0] = CRED;
            m_credit[1] = CRED;
            return;
        end
        for (int p = 0; p < 2; p++) begin
            int g, r;
            g = ((p == 0 ? e0 : e1) >= 0) ? 1 : 0;
            r = (cr[p] && m_credit[p] < CRED) ? 1 : 0;
            m_credit[p] = m_credit[p] - g + r;
        end
        if (fl) begin
            for (int i = 0; i < NE; i++) begin
                m_pend[i] = 0;
                m_starve[i] = 0;
            end
        end else if (e) begin
            for (int i = 0; i < NE; i++) begin
                bit gr, el;
                gr = (i == e0) || (i == e1);
                el = rq[i] && !m_pend[i];
                m_pend[i] = gr || (m_pend[i] && rq[i]);
                if (gr || !el) m_starve[i] = 0;
                else if (m_starve[i] < LIMIT) m_starve[i] = m_starve[i] + 1;
            end
        end
        if (e0 >= 0 || e1 >= 0) begin
            case (rt)
                NONE:    m_ptr = 0;
                JUMPING: begin
                    m_ptr = (m_ptr + NE / 2 + m_tog) % NE;
                    m_tog = 1 - m_tog;
                end
                default: m_ptr = (m_ptr + 1) % NE;
            endcase
        end
    endtask

    // One clock: drive, compare against the model, advance the model at the edge.
    task automatic step(input logic rst, input logic [NE-1:0] rq, input logic e, input logic fl,
                        input rotation_type_t rt, input logic [1:0] cr);
        logic [NE-1:0] x0, x1;
        @(negedge clock);
        cyc++;
        reset = rst;
        req = rq;
        en = e;
        flush = fl;
        rotator = rt;
        credit_return = cr;
        #1;
        predict(rst, rq, e, fl);
        x0 = '0;
        x1 = '0;
        if (e0 >= 0) x0[e0] = 1'b1;
        if (e1 >= 0) x1[e1] = 1'b1;
        s_gnt0 = gnt0;
        s_gnt1 = gnt1;
        s_idx0 = gnt0_idx;
        s_idx1 = gnt1_idx;
        s_valid = gnt_valid;
        check("gnt0", int'(gnt0), int'(x0));
        check("gnt1", int'(gnt1), int'(x1));
        check("gnt0_idx", int'(gnt0_idx), e0 < 0 ? 0 : e0);
        check("gnt1_idx", int'(gnt1_idx), e1 < 0 ? 0 : e1);
        check("gnt_valid", int'(gnt_valid), ((e1 >= 0) ? 2 : 0) + ((e0 >= 0) ? 1 : 0));
        @(posedge clock);
        update(rst, rq, e, fl, rt, cr);
    endtask

    initial begin
        logic [NE-1:0] rq;
        logic [1:0] cr;
        logic rst, e, fl;
        rotation_type_t rt;

        reset = 1'b1;
        req = '0;
        en = 1'b0;
        flush = 1'b0;
        rotator = WALKING;
        credit_return = '0;
        update(1'b1, '0, 1'b0, 1'b0, WALKING, 2'b00);

        // Reset and basic dual-port pick
        step(1, 8'h00, 1, 0, WALKING, 2'b00);
        check("reset_valid", int'(s_valid), 0);
        step(0, 8'b1001_0010, 1, 0, WALKING, 2'b00);
        check("t1_idx0", int'(s_idx0), 1);
        check("t1_idx1", int'(s_idx1), 7);
        check("t1_valid", int'(s_valid), 3);
        #1;
        check("t1_pend", int'(dut.pend), 8'h82);
        check("t1_ptr", int'(dut.ptr), 1);

        // Single entry: port 0 takes it, port 1 only when port 0 is out of credit
        step(0, 8'b0000_0100, 1, 0, WALKING, 2'b11);
        check("t2_idx0", int'(s_idx0), 2);
        check("t2_valid0", int'(s_valid), 1);
        step(0, 8'h00, 1, 0, WALKING, 2'b00);
        step(0, 8'b0000_0100, 1, 0, WALKING, 2'b00);
        step(0, 8'h00, 1, 0, WALKING, 2'b00);
        step(0, 8'b0000_0100, 1, 0, WALKING, 2'b00);
        check("t2_valid1", int'(s_valid), 2);
        check("t2_idx1", int'(s_idx1), 2);
        check("t2_gnt0", int'(s_gnt0), 0);

        // Port-0 credit exhaustion and recovery
        step(1, 8'h00, 1, 0, WALKING, 2'b00);
        step(0, 8'h01, 1, 0, WALKING, 2'b00);
        step(0, 8'h00, 1, 0, WALKING, 2'b00);
        step(0, 8'h01, 1, 0, WALKING, 2'b00);
        step(0, 8'h00, 1, 0, WALKING, 2'b00);
        step(0, 8'h01, 1, 0, WALKING, 2'b00);
        check("t3_no_port0", int'(s_valid), 2);
        step(0, 8'h00, 1, 0, WALKING, 2'b01);
        step(0, 8'h01, 1, 0, WALKING, 2'b00);
        check("t3_port0_back", int'(s_valid), 1);

        // Held request issues exactly once until it drops and rises again
        step(1, 8'h00, 1, 0, WALKING, 2'b00);
        step(0, 8'h20, 1, 0, WALKING, 2'b00);
        check("t4_first", int'(s_gnt0), 8'h20);
        for (int k = 0; k < 3; k++) begin
            step(0, 8'h20, 1, 0, WALKING, 2'b00);
            check("t4_held", int'(s_valid), 0);
        end
        step(0, 8'h00, 1, 0, WALKING, 2'b00);
        step(0, 8'h20, 1, 0, WALKING, 2'b00);
        check("t4_reissue", int'(s_gnt0), 8'h20);

        // Flush squashes grants and clears pending
        step(1, 8'h00, 1, 0, WALKING, 2'b00);
        step(0, 8'hFF, 1, 0, WALKING, 2'b00);
        step(0, 8'hFF, 1, 1, WALKING, 2'b00);
        check("t6_flush_valid", int'(s_valid), 0);
        #1;
        check("t6_flush_pend", int'(dut.pend), 0);
        step(0, 8'h01, 1, 0, WALKING, 2'b00);
        check("t6_after_flush", int'(s_gnt0), 8'h01);

        // Jumping pointer sequence 4,1,5,2
        step(1, 8'h00, 1, 0, JUMPING, 2'b00);
        step(0, 8'h01, 1, 0, JUMPING, 2'b00);
        #1;
        check("t6_jump1", int'(dut.ptr), 4);
        step(0, 8'h02, 1, 0, JUMPING, 2'b01);
        #1;
        check("t6_jump2", int'(dut.ptr), 1);
        step(0, 8'h01, 1, 0, JUMPING, 2'b01);
        #1;
        check("t6_jump3", int'(dut.ptr), 5);
        step(0, 8'h02, 1, 0, JUMPING, 2'b01);
        #1;
        check("t6_jump4", int'(dut.ptr), 2);

        // Starvation: entry 3 keeps losing to 0/1 and 7/6, forced after LIMIT waiting cycles
        step(1, 8'h00, 1, 0, NONE, 2'b00);
        for (int j = 1; j <= LIMIT + 1; j++) begin
            step(0, (j % 2) ? 8'h89 : 8'h4A, 1, 0, NONE, (j == 1) ? 2'b00 : 2'b11);
            if (j == LIMIT) begin
                check("t5_not_yet_idx0", int'(s_idx0), 0);
                check("t5_not_yet_idx1", int'(s_idx1), 7);
            end
            if (j == LIMIT + 1) begin
                check("t5_forced_idx0", int'(s_idx0), 3);
                check("t5_forced_idx1", int'(s_idx1), 6);
            end
        end

        // Random traffic against the model
        rt = WALKING;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom % 200) == 0;
            e = ($urandom % 10) != 0;
            fl = ($urandom % 30) == 0;
            if (($urandom % 50) == 0) rt = rotation_type_t'(2'($urandom_range(0, 3)));
            for (int i = 0; i < NE; i++) begin
                rq[i] = m_pend[i] ? (($urandom % 2) == 0) : (($urandom % 5) != 0);
            end
            for (int p = 0; p < 2; p++) begin
                cr[p] = rst ? (($urandom % 2) == 0) : ((m_credit[p] < CRED) && (($urandom % 3) == 0));
            end
            step(rst, rq, e, fl, rt, cr);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
